// File: rtl/hamm_pkg.sv
// hamm_pkg: FSM encoding, codeword/data widths and syndrome-to-bit map for the Hamming(7,4) scheduler
package hamm_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, DECODE = 2'd1, OUT = 2'd2} state_t;
  localparam int CW_W = 7;
  localparam int D_W = 4;
  localparam logic [7:0][2:0] SYN_MAP = {3'd0, 3'd4, 3'd2, 3'd6, 3'd1, 3'd5, 3'd3, 3'd0};
endpackage

// File: rtl/hamm74_decode.sv
// hamm74_decode: combinational Hamming(7,4) single-bit correct; ports cw (codeword, MSB is c0), data {c0,c1,c2,c4}, err (correction applied)
module hamm74_decode
  import hamm_pkg::*;
(
  input  logic [CW_W-1:0] cw,
  output logic [D_W-1:0]  data,
  output logic            err
);
  logic [CW_W-1:0] c;
  logic [2:0] s, b;
  always_comb begin
    for (int i = 0; i < CW_W; i++) c[i] = cw[CW_W-1-i];
    s = {c[0] ^ c[2] ^ c[4] ^ c[6], c[0] ^ c[1] ^ c[4] ^ c[5], c[0] ^ c[1] ^ c[2] ^ c[3]};
    err = |s;
    b = SYN_MAP[s];
    data = {c[0] ^ (err && b == 3'd0), c[1] ^ (err && b == 3'd1), c[2] ^ (err && b == 3'd2), c[4] ^ (err && b == 3'd4)};
  end
endmodule

// File: rtl/hamm_rx_sched.sv
// hamm_rx_sched: round-robin scheduler sharing one Hamming(7,4) decoder among N_REQ requesters.
// Ports: clk, rst (async, active high), req_valid/req_data/req_ready (per-requester handshake,
// codeword i at req_data[7i+6:7i] with bit 7i+6 = c0), out_valid/out_ready/out_data/out_src/out_err
// (result handshake), err_count (saturating correction counter, only with HAMM_ERRCNT_EN defined).
module hamm_rx_sched
  import hamm_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int SRC_W = 2,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [CW_W*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]      req_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [D_W-1:0]        out_data,
  output logic [SRC_W-1:0]      out_src,
  output logic                  out_err
`ifdef HAMM_ERRCNT_EN
  ,
  output logic [CNT_W-1:0]      err_count
`endif
);
  if (N_REQ < 2 || N_REQ > 8 || SRC_W != $clog2(N_REQ) || CNT_W < 1) begin : g_bad_cfg
    $error("hamm_rx_sched: inconsistent parameters");
  end
  state_t state;
  logic [SRC_W-1:0] rr_ptr, g, idx, lat_src;
  logic [CW_W-1:0] lat_cw;
  logic [CW_W-1:0] words [N_REQ];
  logic [D_W-1:0] dec_data;
  logic dec_err;
  for (genvar i = 0; i < N_REQ; i++) begin : g_w
    assign words[i] = req_data[CW_W*i +: CW_W];
  end
  // Scan downward so the nearest valid index at or after rr_ptr is the last one to win.
  always_comb begin
    g = '0;
    idx = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = SRC_W'((int'(rr_ptr) + k) % N_REQ);
      if (req_valid[idx]) g = idx;
    end
    req_ready = (state == IDLE && |req_valid) ? N_REQ'(1) << g : '0;
  end
  hamm74_decode u_dec (.cw(lat_cw), .data(dec_data), .err(dec_err));
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      rr_ptr <= '0;
      lat_src <= '0;
      lat_cw <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
      out_src <= '0;
      out_err <= 1'b0;
    end else begin
      case (state)
        IDLE: if (|req_valid) begin
          lat_cw <= words[g];
          lat_src <= g;
          state <= DECODE;
        end
        DECODE: begin
          out_data <= dec_data;
          out_src <= lat_src;
          out_err <= dec_err;
          out_valid <= 1'b1;
          state <= OUT;
        end
        OUT: if (out_ready) begin
          out_valid <= 1'b0;
          rr_ptr <= (lat_src == SRC_W'(N_REQ - 1)) ? '0 : lat_src + SRC_W'(1);
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
`ifdef HAMM_ERRCNT_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) err_count <= '0;
    else if (state == OUT && out_ready && out_err && err_count != '1) err_count <= err_count + CNT_W'(1);
`endif
endmodule

// File: doc/hamm_rx_sched.md
# hamm_rx_sched

Round-robin scheduler sharing one Hamming(7,4) correct/decode datapath among `N_REQ` requesters. Each requester offers a 7-bit codeword over a valid/ready handshake. The block grants one requester at a time, latches its codeword, decodes it with single-bit correction, and presents the 4-bit nibble with source ID and a corrected flag on a single output handshake. It sits between the per-channel receive buffers and the display/consumer logic.

## Interface
Parameters:
- `N_REQ`, default 4: number of requesters, 2..8.
- `SRC_W`, default 2: source-ID width, equal to clog2(`N_REQ`).
- `CNT_W`, default 16: error-counter width.

Ports:
- `clk`  in  1: rising-edge clock.
- `rst`  in  1: asynchronous, active-high reset.
- `req_valid`  in  `N_REQ`: requester i offers a codeword.
- `req_data`  in  7*`N_REQ`: codeword i occupies bits [7i+6:7i]. Bit 7i+6 is codeword bit 0.
- `req_ready`  out  `N_REQ`: one-hot accept strobe.
- `out_valid`  out  1: decoded result available.
- `out_ready`  in  1: consumer accepts the result.
- `out_data`  out  4: corrected data nibble {c0,c1,c2,c4}.
- `out_src`  out  `SRC_W`: index of the granted requester.
- `out_err`  out  1: a single-bit correction was applied.
- `err_count`  out  `CNT_W`: present only with `HAMM_ERRCNT_EN`.

## Operation
- FSM states are IDLE, DECODE and OUT. Reset state is IDLE.
- IDLE:
  - If any `req_valid` is set, grant the first valid index at or after `rr_ptr`, wrapping modulo `N_REQ`.
  - Pulse `req_ready[g]` combinationally in this cycle.
  - Latch `req_data[g]` and `g`, then go to DECODE.
  - If no `req_valid` is set, stay in IDLE.
- DECODE:
  - Syndrome s = {c0^c2^c4^c6, c0^c1^c4^c5, c0^c1^c2^c3}.
  - If s ≠ 0, flip bit index: s=7→0, 3→1, 5→2, 1→3, 6→4, 2→5, 4→6.
  - Register `out_data`, `out_src`, and `out_err` = (s≠0), then go to OUT.
- OUT:
  - Hold `out_valid`=1 with all outputs stable until `out_ready`=1.
  - On the handshake, set `rr_ptr` = (g+1) mod `N_REQ` and return to IDLE.
- `req_ready` is never asserted outside IDLE. At most one bit is set.
- Requesters that drop `req_valid` before being granted are simply skipped. This is not an error.
- Double-bit errors are miscorrected silently. Detecting them is out of scope.

## Timing
- Reset values: `req_ready`=0, `out_valid`=0, `out_data`=0, `out_src`=0, `out_err`=0, `err_count`=0, `rr_ptr`=0, state IDLE.
- Latency: accept in cycle t, `out_valid` high from cycle t+2.
- Throughput: 3 cycles per word when `out_ready` is held high. Backpressure stalls the block in OUT indefinitely.
- `out_valid` and `out_ready` both high in cycle t means the next accept occurs at the earliest in cycle t+1.
- Reset asserted mid-operation: the in-flight word is discarded, outputs drop to reset values immediately (asynchronously), and the round-robin pointer returns to 0.
- A single valid requester is re-granted every 3 cycles. Fairness: any continuously valid requester is granted within `N_REQ` grants.

## Configuration
- `HAMM_ERRCNT_EN` defined:
  - `err_count` is incremented on each output handshake with `out_err`=1.
  - It saturates at 2^`CNT_W`−1 and does not wrap.
  - It is cleared only by `rst`.
- `HAMM_ERRCNT_EN` undefined: the `err_count` port and its counter logic are absent.

## Structure
- Package `hamm_pkg`:
  - FSM state encoding (IDLE=0, DECODE=1, OUT=2).
  - Codeword width 7 and data width 4.
  - Syndrome-to-bit-index constant map.
- Sub-module `hamm74_decode`: combinational. Takes a 7-bit codeword and produces the 4-bit nibble and the err flag. The FSM instantiates it once, between the latch and the output register.

## Test plan
- Requester 0 offers 0000000 with `out_ready`=1 → `req_ready`=0001 at t, and at t+2 `out_data`=0000, `out_src`=0, `out_err`=0.
- Requester 2 offers 0000001 → syndrome 4, bit 6 flipped → `out_data`=0000, `out_src`=2, `out_err`=1.
- Requester 1 offers 0111111 → syndrome 7, bit 0 flipped → `out_data`=1111, `out_err`=1.
- All 4 requesters valid continuously → grant order 0,1,2,3,0, one grant every 3 cycles.
- Result in OUT with `out_ready`=0 for 10 cycles → outputs stable and no `req_ready`. Raise `out_ready` → next grant in the following cycle.
- Assert `rst` during DECODE → `out_valid`=0 with no result emitted. With `HAMM_ERRCNT_EN`: 3 corrected words give `err_count`=3, and `rst` returns it to 0.
